gray_packer: RTL

GRAY_PACKER -- requirements
Module: gray_packer

---
 rtl/gray_pkg.sv | 8 +
 rtl/gray_packer.sv | 76 +++++++
 2 files changed

// File: rtl/gray_pkg.sv
// Pixel-format constants shared by the grayscale stage and the packer.
package gray_pkg;

   localparam int unsigned DATA_WIDTH = 8;
   localparam int unsigned PACK       = 4;
   localparam int unsigned LANE_W     = $clog2(PACK);

endpackage

// File: rtl/gray_packer.sv
// Packs PACK grayscale pixels into one AXI-Stream word; short words close early on s_tlast.
module gray_packer #(
   parameter int unsigned DATA_WIDTH = gray_pkg::DATA_WIDTH,
   parameter int unsigned PACK       = gray_pkg::PACK,
   parameter int unsigned FCNT_WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic [DATA_WIDTH-1:0]        s_tdata,
   input  logic                         s_tvalid,
   input  logic                         s_tlast,
   output logic                         s_tready,
   output logic [PACK*DATA_WIDTH-1:0]   m_tdata,
   output logic [PACK-1:0]              m_tkeep,
   output logic                         m_tlast,
   output logic                         m_tvalid,
   input  logic                         m_tready,
   output logic [FCNT_WIDTH-1:0]        frame_cnt
);

   localparam int unsigned LANE_W = $clog2(PACK);
   localparam int unsigned WORD_W = PACK * DATA_WIDTH;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK - 1);

   logic [LANE_W-1:0] lane;
   logic [WORD_W-1:0] acc;
   logic [WORD_W-1:0] word_c;
   logic [PACK-1:0]   keep_c;
   logic              accept_c;
   logic              close_c;

   assign s_tready = rstn && (!m_tvalid || m_tready);
   assign accept_c = s_tvalid && s_tready;
   assign close_c  = accept_c && ((lane == LAST_LANE) || s_tlast);

   // Lanes above the write lane are still zero in acc, so the merged word needs no masking.
   always_comb begin
      word_c = acc;
      keep_c = '0;
      for (int unsigned i = 0; i < PACK; i++) begin
         if (LANE_W'(i) == lane) word_c[i*DATA_WIDTH +: DATA_WIDTH] = s_tdata;
         if (LANE_W'(i) <= lane) keep_c[i] = 1'b1;
      end
   end

   // Output register, accumulator, lane counter and frame counter.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_tvalid  <= 1'b0;
         m_tdata   <= '0;
         m_tkeep   <= '0;
         m_tlast   <= 1'b0;
         frame_cnt <= '0;
         lane      <= '0;
         acc       <= '0;
      end else begin
         if (m_tvalid && m_tready) begin
            m_tvalid <= 1'b0;
            if (m_tlast) frame_cnt <= frame_cnt + FCNT_WIDTH'(1);
         end
         // A close on the draining edge overrides the drop, giving back-to-back words.
         if (close_c) begin
            m_tvalid <= 1'b1;
            m_tdata  <= word_c;
            m_tkeep  <= keep_c;
            m_tlast  <= s_tlast;
            acc      <= '0;
            lane     <= '0;
         end else if (accept_c) begin
            acc  <= word_c;
            lane <= lane + LANE_W'(1);
         end
      end
   end

endmodule
